alu_multicycle: RTL
===================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH SHALL default to 32 and set the operand/result width; the shift amount width SHALL be log2(WIDTH), which is 5 at the default.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 in_valid  input  1  SHALL indicate that an operation request is present.
REQ-005 in_ready  output  1  SHALL indicate that the block can accept a request.
REQ-006 ALUControl  input  4  SHALL be the operation code produced by the ALU decoder.
REQ-007 SrcA  input  WIDTH  SHALL be operand A.
REQ-008 SrcB  input  WIDTH  SHALL be operand B; for shifts, SrcB[4:0] SHALL be the shift amount (shamt).
REQ-009 out_valid  output  1  SHALL indicate that a result is present.
REQ-010 out_ready  input  1  SHALL indicate that the consumer accepts the result.
REQ-011 ALUResult  output  WIDTH  SHALL carry the operation result.
REQ-012 Zero  output  1  SHALL be 1 when ALUResult == 0.
REQ-013 illegal  output  1  SHALL be 1 when the accepted ALUControl code is unsupported.

Function
REQ-014 The block SHALL support these codes:
- 0000 add: A+B
- 0001 sub: A-B
- 0010 and
- 0011 or
- 0100 xor
- 0101 slt: signed A<B gives 1, else 0
- 1001 sltu: unsigned compare
- 1000 sll
- 0111 srl
- 0110 sra
REQ-015 Add and sub SHALL wrap modulo 2^WIDTH, with no carry or overflow output.
REQ-016 The state machine SHALL have three states: IDLE, SHIFT and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE.
- A request SHALL be accepted on a rising edge where in_valid && in_ready.
- On acceptance, ALUControl, SrcA and shamt SHALL be captured.
REQ-018 On acceptance of a non-shift code, or of a shift code with shamt == 0:
- The result SHALL be computed and registered.
- The state SHALL go to DONE.
- Latency SHALL be 1 cycle: out_valid is high on the cycle after acceptance.
REQ-019 On acceptance of a shift code with shamt != 0:
- The state SHALL go to SHIFT, with the working register = SrcA and the counter = shamt.
REQ-020 In SHIFT, on each cycle:
- The working register SHALL shift by exactly one bit: sll fills 0 at bit 0, srl fills 0 at the MSB, sra replicates the MSB.
- The counter SHALL decrement by 1.
- When the counter goes 1 to 0, the state SHALL go to DONE.
- Shift latency SHALL therefore be shamt+1 cycles, from acceptance to out_valid.
REQ-021 In DONE:
- out_valid SHALL be 1.
- ALUResult, Zero and illegal SHALL be held stable until out_ready == 1.
- On out_ready, the state SHALL return to IDLE.
REQ-022 in_valid SHALL be ignored outside IDLE; a new request cannot be accepted in the same cycle a result is consumed, so the minimum issue interval is 2 cycles.
REQ-023 For an unsupported code (1010 to 1111):
- ALUResult SHALL be 0, Zero SHALL be 1 and illegal SHALL be 1.
- Latency SHALL be 1 cycle.
REQ-024 For supported codes, illegal SHALL be 0.
REQ-025 Outside DONE:
- out_valid SHALL be 0.
- ALUResult SHALL hold its last value.
- Zero SHALL track ALUResult.
REQ-026 The upper bits of SrcB (SrcB[31:5]) SHALL be ignored for shifts.

Reset
REQ-027 While reset is high, the block SHALL be in IDLE with:
- in_ready = 1, out_valid = 0
- ALUResult = 0, Zero = 1, illegal = 0
- the counter and the working register = 0
REQ-028 Reset asserted mid-SHIFT or in DONE SHALL abort the operation without producing a result; the first acceptance after reset deasserts SHALL behave normally.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Add: code 0000, A=0xFFFFFFFF, B=1 -> one cycle later out_valid=1, ALUResult=0, Zero=1.
- Signed compare: slt with A=0xFFFFFFFF, B=1 -> ALUResult=1; sltu with the same operands -> ALUResult=0.
- Arithmetic shift: sra with A=0x80000000, B=4 -> out_valid exactly 5 cycles after acceptance, ALUResult=0xF8000000; in_ready=0 throughout.
- Zero shift: sll with shamt=0, A=0x1234 -> 1-cycle latency, ALUResult=0x1234. srl with B=0xFFFFFFE3 -> shamt=3 is used.
- Backpressure and illegal code: out_ready held 0 for 4 cycles in DONE -> result stable and no new acceptance despite in_valid=1. Code 1100 -> illegal=1, ALUResult=0.
- Reset mid-operation: reset asserted mid-SHIFT of sll by 20 -> immediately in_ready=1, out_valid=0, ALUResult=0. A following add of 2+3 -> 5.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with a valid/ready request and result handshake.
// Shifts walk one bit per cycle; everything else finishes in one cycle.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             illegal
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state, state_n;
    logic [3:0]        op_q;
    logic [WIDTH-1:0]  work_q;
    logic [SW-1:0]     cnt_q;
    logic [WIDTH-1:0]  res_q;
    logic              ill_q;

    logic [SW-1:0]     shamt;
    logic              is_shift;
    logic              start_shift;
    logic [WIDTH-1:0]  comb_res;
    logic              comb_ill;
    logic [WIDTH-1:0]  step_res;
    logic              last_step;

    assign shamt       = SrcB[SW-1:0];
    assign is_shift    = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) ||
                         (ALUControl == OP_SRA);
    assign start_shift = is_shift && (shamt != '0);
    assign last_step   = (cnt_q == SW'(1));

    // Single-cycle result for every code, including zero-distance shifts.
    always_comb begin
        comb_res = '0;
        comb_ill = 1'b0;
        case (ALUControl)
            OP_ADD:  comb_res = SrcA + SrcB;
            OP_SUB:  comb_res = SrcA - SrcB;
            OP_AND:  comb_res = SrcA & SrcB;
            OP_OR:   comb_res = SrcA | SrcB;
            OP_XOR:  comb_res = SrcA ^ SrcB;
            OP_SLT:  comb_res = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            OP_SLTU: comb_res = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
            OP_SLL:  comb_res = SrcA << shamt;
            OP_SRL:  comb_res = SrcA >> shamt;
            OP_SRA:  comb_res = WIDTH'($signed(SrcA) >>> shamt);
            default: comb_ill = 1'b1;
        endcase
    end

    // One-bit shift step of the working register, direction from the held op.
    always_comb begin
        step_res = work_q;
        case (op_q)
            OP_SLL:  step_res = {work_q[WIDTH-2:0], 1'b0};
            OP_SRL:  step_res = {1'b0, work_q[WIDTH-1:1]};
            OP_SRA:  step_res = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: step_res = work_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = start_shift ? SHIFT : DONE;
            end
            SHIFT: begin
                if (last_step) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: capture on accept, step while shifting, hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= '0;
            work_q <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            ill_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= ALUControl;
                        if (start_shift) begin
                            work_q <= SrcA;
                            cnt_q  <= shamt;
                            ill_q  <= 1'b0;
                        end else begin
                            res_q <= comb_res;
                            ill_q <= comb_ill;
                        end
                    end
                end
                SHIFT: begin
                    work_q <= step_res;
                    cnt_q  <= cnt_q - 1'b1;
                    if (last_step) res_q <= step_res;
                end
                default: ;
            endcase
        end
    end

    assign ALUResult = res_q;
    assign Zero      = (res_q == '0);
    assign illegal   = ill_q;

endmodule
